// File: rtl/fifo_burst_drain_ctrl.sv
// Burst drain controller: empties N_CH channel FIFOs into the packetiser in fixed bursts separated by idle gaps.
// Optional statistics counters (burst_cnt, abort_cnt) are built when FIFO_BURST_DRAIN_STATS_EN is defined.
module fifo_burst_drain_ctrl #(
  parameter int N_CH      = 6,
  parameter int ADDR_W    = $clog2(N_CH),
  parameter int BURST_LEN = 1024,
  parameter int GAP_LEN   = 8192,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [N_CH-1:0]   empty,
  input  logic              eth_ready,
  input  logic              rr_mode,
  output logic              eth_en,
  output logic [N_CH-1:0]   rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              burst_start,
  output logic              burst_done
`ifdef FIFO_BURST_DRAIN_STATS_EN
  ,
  output logic [31:0]       burst_cnt,
  output logic [15:0]       abort_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [ADDR_W:0]   N_CH_W     = (ADDR_W + 1)'(N_CH);
  localparam logic [ADDR_W-1:0] LAST_CH    = ADDR_W'(N_CH - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;

  logic                all_empty;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   sel;
  logic [ADDR_W-1:0]   idx_w [N_CH];
  logic [N_CH-1:0]     req_w;

  assign all_empty = &empty;
  assign base      = rr_mode ? ptr_reg : '0;

  // Channel visited at search offset gi, starting from base and wrapping at N_CH.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] wrap;
    assign sum          = {1'b0, base} + (ADDR_W + 1)'(gi);
    assign wrap         = sum - N_CH_W;
    assign idx_w[gi]    = (sum >= N_CH_W) ? wrap[ADDR_W-1:0] : sum[ADDR_W-1:0];
    assign req_w[gi]    = ~empty[idx_w[gi]];
  end

  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_w[i]) sel = idx_w[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    eth_en      = 1'b0;
    rd_en       = '0;
    addr        = '0;
    burst_start = 1'b0;
    burst_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !all_empty) state_next = READ;
      end
      READ: begin
        addr = sel;
        if (all_empty) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (eth_ready) begin
          eth_en      = 1'b1;
          rd_en       = N_CH'(1) << sel;
          burst_start = (cnt_reg == '0);
          if (rr_mode) ptr_next = (sel == LAST_CH) ? '0 : sel + ADDR_W'(1);
          if (cnt_reg == BURST_LAST) begin
            burst_done = 1'b1;
            cnt_next   = '0;
            state_next = (GAP_LEN == 0) ? READ : GAP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      GAP: begin
        addr = sel;
        if (all_empty) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = READ;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef FIFO_BURST_DRAIN_STATS_EN
  // abort_cnt only counts bursts cut short by the bank draining, not gap exits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (burst_done) burst_cnt <= burst_cnt + 32'd1;
      if (state_reg == READ && all_empty && abort_cnt != 16'hFFFF)
        abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// Scoreboard bench: a queue-based reference model runs two configurations (4/3 and 1/0 burst/gap) side by side.
`timescale 1ns/100ps
module tb_fifo_burst_drain_ctrl;
  localparam int N = 3;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, eth_ready = 1'b0, rr_mode = 1'b0;
  logic [2:0] empty = 3'b111;
  logic en0, bs0, bd0, en1, bs1, bd1;
  logic [2:0] rd0, rd1;
  logic [1:0] ad0, ad1;
  logic [31:0] bc0, bc1;
  logic [15:0] ac0, ac1;

  int errors = 0, checks = 0, cyc = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  rd;
    logic [1:0]  ad;
    logic        bs;
    logic        bd;
    logic [31:0] bc;
    logic [15:0] ac;
  } rec_t;
  rec_t rq0[$], iq0[$], rq1[$], iq1[$];

  int ph[2], cnt[2], ptr[2], acm[2];
  int unsigned bcm[2];
  int bl[2] = '{4, 1};
  int gl[2] = '{3, 0};

  fifo_burst_drain_ctrl #(.N_CH(3), .BURST_LEN(4), .GAP_LEN(3), .CNT_W(16)) d0 (
    .clk(clk), .rstn(rstn), .start(start), .empty(empty), .eth_ready(eth_ready), .rr_mode(rr_mode),
    .eth_en(en0), .rd_en(rd0), .addr(ad0), .burst_start(bs0), .burst_done(bd0)
`ifdef FIFO_BURST_DRAIN_STATS_EN
    , .burst_cnt(bc0), .abort_cnt(ac0)
`endif
  );
  fifo_burst_drain_ctrl #(.N_CH(3), .BURST_LEN(1), .GAP_LEN(0), .CNT_W(16)) d1 (
    .clk(clk), .rstn(rstn), .start(start), .empty(empty), .eth_ready(eth_ready), .rr_mode(rr_mode),
    .eth_en(en1), .rd_en(rd1), .addr(ad1), .burst_start(bs1), .burst_done(bd1)
`ifdef FIFO_BURST_DRAIN_STATS_EN
    , .burst_cnt(bc1), .abort_cnt(ac1)
`endif
  );
`ifndef FIFO_BURST_DRAIN_STATS_EN
  assign bc0 = '0; assign bc1 = '0; assign ac0 = '0; assign ac1 = '0;
`endif

  always #5 clk = ~clk;

  // Phases: 0 idle, 1 bursting, 2 gap. cnt counts words read or gap cycles spent.
  task automatic model_step(input int k, output logic en, output rec_t r);
    int sel, base;
    bit found, ae;
    r.cyc = cyc; r.rd = '0; r.ad = '0; r.bs = 1'b0; r.bd = 1'b0; en = 1'b0;
    if (!rstn) begin
      ph[k] = 0; cnt[k] = 0; ptr[k] = 0; bcm[k] = 0; acm[k] = 0;
      r.bc = '0; r.ac = '0;
      return;
    end
    r.bc = bcm[k]; r.ac = 16'(acm[k]);
    ae = (empty == 3'b111);
    base = rr_mode ? ptr[k] : 0;
    sel = 0; found = 0;
    for (int j = 0; j < N; j++)
      if (!found && !empty[(base + j) % N]) begin sel = (base + j) % N; found = 1; end
    case (ph[k])
      0: if (start && !ae) ph[k] = 1;
      1: begin
        r.ad = sel[1:0];
        if (ae) begin
          ph[k] = 0; cnt[k] = 0;
          if (acm[k] < 65535) acm[k]++;
        end else if (eth_ready) begin
          en = 1'b1;
          r.rd = 3'(1 << sel);
          r.bs = (cnt[k] == 0);
          r.bd = (cnt[k] == bl[k] - 1);
          if (rr_mode) ptr[k] = (sel + 1) % N;
          cnt[k]++;
          if (cnt[k] == bl[k]) begin
            cnt[k] = 0; bcm[k]++;
            ph[k] = (gl[k] == 0) ? 1 : 2;
          end
        end
      end
      default: begin
        r.ad = sel[1:0];
        if (ae) begin
          ph[k] = 0; cnt[k] = 0;
        end else begin
          cnt[k]++;
          if (cnt[k] == gl[k]) begin cnt[k] = 0; ph[k] = 1; end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin : model_proc
    rec_t r;
    logic en;
    cyc++;
    #3;
    model_step(0, en, r);
    if (en) rq0.push_back(r); else iq0.push_back(r);
    model_step(1, en, r);
    if (en) rq1.push_back(r); else iq1.push_back(r);
  end

  task automatic check_inst(input int k, input logic en, input logic [2:0] rd, input logic [1:0] ad,
                            input logic bs, input logic bd, input logic [31:0] bc, input logic [15:0] ac);
    rec_t e;
    bit ok, have;
    checks++;
    have = 0;
    if (en) begin
      if (k == 0 && rq0.size() > 0) begin e = rq0.pop_front(); have = 1; end
      if (k == 1 && rq1.size() > 0) begin e = rq1.pop_front(); have = 1; end
    end else begin
      if (k == 0 && iq0.size() > 0) begin e = iq0.pop_front(); have = 1; end
      if (k == 1 && iq1.size() > 0) begin e = iq1.pop_front(); have = 1; end
    end
    if (!have) begin
      errors++;
      $display("FAIL inst%0d read_presence cyc=%0d actual eth_en=%b rd_en=%b required eth_en=%b", k, cyc, en, rd, !en);
      return;
    end
    ok = (e.cyc == cyc) && (e.rd == rd) && (e.ad == ad) && (e.bs == bs) && (e.bd == bd);
`ifdef FIFO_BURST_DRAIN_STATS_EN
    ok = ok && (e.bc == bc) && (e.ac == ac);
`endif
    if (!ok) begin
      errors++;
      $display("FAIL inst%0d %s cyc=%0d actual rd_en=%b addr=%0d bs=%b bd=%b bcnt=%0d acnt=%0d required cyc=%0d rd_en=%b addr=%0d bs=%b bd=%b bcnt=%0d acnt=%0d",
               k, en ? "read" : "idle", cyc, rd, ad, bs, bd, bc, ac, e.cyc, e.rd, e.ad, e.bs, e.bd, e.bc, e.ac);
    end
  endtask

  always @(posedge clk) begin
    #4;
    check_inst(0, en0, rd0, ad0, bs0, bd0, bc0, ac0);
    check_inst(1, en1, rd1, ad1, bs1, bd1, bc1, ac1);
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_model(input int p, input int c, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ph[0] == p && cnt[0] == c) return;
      cycles(1);
    end
    checks++; errors++;
    $display("FAIL wait_timeout actual phase=%0d count=%0d required phase=%0d count=%0d", ph[0], cnt[0], p, c);
  endtask

  initial begin
    empty = 3'b000;
    cycles(3);
    rstn = 1'b1;
    // fixed priority, then round robin, then round robin with ch1 empty
    start = 1'b1; eth_ready = 1'b1; rr_mode = 1'b0;
    cycles(20);
    rr_mode = 1'b1;
    cycles(20);
    empty = 3'b010;
    cycles(16);
    empty = 3'b000; rr_mode = 1'b0;
    // backpressure mid-burst
    wait_model(1, 2, 30);
    eth_ready = 1'b0;
    cycles(5);
    eth_ready = 1'b1;
    cycles(12);
    // drain abort after the second read, then re-arm
    wait_model(1, 2, 30);
    empty = 3'b111; start = 1'b0;
    cycles(3);
    empty = 3'b000;
    cycles(3);
    start = 1'b1;
    cycles(10);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      empty     = 3'($urandom_range(0, 7));
      eth_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      cycles(1);
    end
    // async reset mid-gap, between clock edges; addr shows ch1 during the gap
    empty = 3'b001; start = 1'b1; eth_ready = 1'b1; rr_mode = 1'b0;
    wait_model(2, 1, 40);
    #1;
    rstn = 1'b0;
    #0.5;
    checks++;
    if ({en0, rd0, ad0, bs0, bd0, en1, rd1, ad1, bs1, bd1} != '0) begin
      errors++;
      $display("FAIL async_reset_outputs actual d0 en=%b rd=%b addr=%0d bs=%b bd=%b d1 en=%b rd=%b addr=%0d required all zero",
               en0, rd0, ad0, bs0, bd0, en1, rd1, ad1);
    end
    start = 1'b0;
    cycles(3);
    rstn = 1'b1;
    cycles(4);
    start = 1'b1;
    cycles(15);
    @(posedge clk); #5;
    checks++;
    if (rq0.size() + iq0.size() + rq1.size() + iq1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual %0d entries required 0", rq0.size() + iq0.size() + rq1.size() + iq1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
